// File: rtl/cellrv32_sysinfo_ext.sv
// System information unit: read-only configuration ROM, hart info, lockable scratch
// registers, boot-flag control and (with CELLRV32_SYSINFO_UPTIME_EN) a 64-bit uptime counter.
module cellrv32_sysinfo_ext #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFFFE00,
    parameter logic [31:0] CLOCK_FREQUENCY = 32'h0,
    parameter logic [31:0] CUSTOM_ID       = 32'h0,
    parameter logic [31:0] FEATURE_VEC     = 32'h0,
    parameter logic [31:0] CACHE_CFG       = 32'h0,
    parameter logic [31:0] ISPACE_BASE     = 32'h00000000,
    parameter logic [31:0] DSPACE_BASE     = 32'h80000000,
    parameter logic [31:0] IMEM_SIZE       = 32'h0,
    parameter logic [31:0] DMEM_SIZE       = 32'h0,
    parameter int          NUM_HARTS       = 1,
    parameter int          NUM_SCRATCH     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        rden_i,
    input  logic        wren_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o
);

    // Bus protocol: a one-cycle rden_i/wren_i pulse inside the window is answered on the
    // following cycle by exactly one of ack_o/err_o; data_o is nonzero only with a read ack.
    logic        acc_en, rd_req, wr_req, both_req;
    logic [5:0]  widx;
    logic [3:0]  scr_idx;
    logic        in_scr;
    logic        rd_ok, wr_ok, ctrl_we, scr_we, clr_we;
    logic [31:0] rd_data;
    logic        lock_q, boot_q;
    logic [31:0] scratch_q [NUM_SCRATCH];
    logic        unused_addr_lsb;

    assign acc_en          = (addr_i[31:8] == BASE_ADDR[31:8]);
    assign widx            = addr_i[7:2];
    assign unused_addr_lsb = ^addr_i[1:0];
    assign rd_req          = acc_en & rden_i & ~wren_i;
    assign wr_req          = acc_en & wren_i & ~rden_i;
    assign both_req        = acc_en & rden_i & wren_i;
    assign scr_idx         = widx[3:0];
    assign in_scr          = (widx[5:4] == 2'b01) && ({1'b0, scr_idx} < 5'(NUM_SCRATCH));

`ifdef CELLRV32_SYSINFO_UPTIME_EN
    logic [63:0] uptime_q;
    logic [31:0] hi_shadow_q;
`endif

    always_comb begin
        rd_data = '0;
        rd_ok   = 1'b1;
        case (widx)
            6'd0:  rd_data = CLOCK_FREQUENCY;
            6'd1:  rd_data = CUSTOM_ID;
            6'd2:  rd_data = FEATURE_VEC;
            6'd3:  rd_data = CACHE_CFG;
            6'd4:  rd_data = ISPACE_BASE;
            6'd5:  rd_data = DSPACE_BASE;
            6'd6:  rd_data = IMEM_SIZE;
            6'd7:  rd_data = DMEM_SIZE;
            6'd8:  rd_data = {24'h0, 4'(NUM_SCRATCH - 1), 4'(NUM_HARTS - 1)};
            6'd9:  rd_data = {30'h0, boot_q, lock_q};
`ifdef CELLRV32_SYSINFO_UPTIME_EN
            6'd10: rd_data = uptime_q[31:0];
            6'd11: rd_data = hi_shadow_q;
`else
            6'd10: rd_data = '0;
            6'd11: rd_data = '0;
`endif
            default: begin
                if (in_scr) begin
                    for (int i = 0; i < NUM_SCRATCH; i++) begin
                        if (scr_idx == 4'(i)) rd_data = scratch_q[i];
                    end
                end else begin
                    rd_ok = 1'b0;
                end
            end
        endcase
    end

    // Lock gates scratch and counter-clear writes, using its value before this write.
    always_comb begin
        wr_ok   = 1'b0;
        ctrl_we = 1'b0;
        scr_we  = 1'b0;
        clr_we  = 1'b0;
        if (widx == 6'd9) begin
            wr_ok   = 1'b1;
            ctrl_we = wr_req;
        end else if (in_scr && !lock_q) begin
            wr_ok  = 1'b1;
            scr_we = wr_req;
        end
`ifdef CELLRV32_SYSINFO_UPTIME_EN
        else if (widx == 6'd10 && !lock_q) begin
            wr_ok  = 1'b1;
            clr_we = wr_req;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= '0;
            ack_o  <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            ack_o  <= (rd_req & rd_ok) | (wr_req & wr_ok);
            err_o  <= both_req | (rd_req & ~rd_ok) | (wr_req & ~wr_ok);
            data_o <= (rd_req & rd_ok) ? rd_data : 32'h0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q <= 1'b0;
            boot_q <= 1'b0;
        end else if (ctrl_we) begin
            lock_q <= lock_q | data_i[0];
            if (!lock_q) boot_q <= data_i[1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
        end else if (scr_we) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (scr_idx == 4'(i)) scratch_q[i] <= data_i;
            end
        end
    end

`ifdef CELLRV32_SYSINFO_UPTIME_EN
    // Shadow captures the high word on the same edge the low word is returned.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            uptime_q    <= '0;
            hi_shadow_q <= '0;
        end else begin
            uptime_q <= clr_we ? 64'h0 : uptime_q + 64'd1;
            if (rd_req && widx == 6'd10) hi_shadow_q <= uptime_q[63:32];
        end
    end
`endif

endmodule

// File: tb/tb_cellrv32_sysinfo_ext.sv
// Bench for cellrv32_sysinfo_ext: driver pushes expected responses from a behavioural
// register-map model into a queue; a monitor compares on every falling edge.
module tb_cellrv32_sysinfo_ext;

    localparam logic [31:0] BASE   = 32'hFFFFFE00;
    localparam logic [31:0] CLK_F  = 32'd100000000;
    localparam logic [31:0] CID    = 32'hC0FFEE01;
    localparam logic [31:0] FEAT   = 32'h00000005;
    localparam logic [31:0] CCFG   = 32'h00001234;
    localparam logic [31:0] ISPACE = 32'h00000000;
    localparam logic [31:0] DSPACE = 32'h80000000;
    localparam logic [31:0] IMEM   = 32'h00004000;
    localparam logic [31:0] DMEM   = 32'h00002000;
    localparam int          HARTS  = 2;
    localparam int          NSCR   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic        rden, wren, ack, err;

    cellrv32_sysinfo_ext #(
        .BASE_ADDR(BASE), .CLOCK_FREQUENCY(CLK_F), .CUSTOM_ID(CID), .FEATURE_VEC(FEAT),
        .CACHE_CFG(CCFG), .ISPACE_BASE(ISPACE), .DSPACE_BASE(DSPACE), .IMEM_SIZE(IMEM),
        .DMEM_SIZE(DMEM), .NUM_HARTS(HARTS), .NUM_SCRATCH(NSCR)
    ) dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .rden_i(rden), .wren_i(wren),
        .data_i(wdata), .data_o(rdata), .ack_o(ack), .err_o(err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // entry = {ack, err, data[31:0], response cycle[31:0]}
    logic [65:0] exp_q[$];

    // ---------------- reference model ----------------
    logic [31:0] m_scr [16];
    logic        m_lock, m_boot;
    logic [31:0] m_shadow;
    logic [63:0] up_base_val;
    int          up_base_cyc;

    function automatic logic [63:0] up_at(input int c);
        return up_base_val + 64'(c - up_base_cyc - 1);
    endfunction

    function automatic logic [31:0] rom_word(input int w);
        case (w)
            0: return CLK_F;
            1: return CID;
            2: return FEAT;
            3: return CCFG;
            4: return ISPACE;
            5: return DSPACE;
            6: return IMEM;
            7: return DMEM;
            default: return 32'(((NSCR - 1) << 4) | (HARTS - 1));
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_scr[i] = '0;
        m_lock      = 1'b0;
        m_boot      = 1'b0;
        m_shadow    = '0;
        up_base_val = '0;
        up_base_cyc = cyc;
    endtask

    // ---------------- driver ----------------
    // Called on a falling edge; request is sampled at rising edge cyc+1.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        int          c, w;
        logic        in_win, e_ack, e_err, old_lock;
        logic [31:0] e_data;
        logic [63:0] v;
        c = cyc + 1;
        w = int'(a[7:2]);
        in_win = (a[31:8] == BASE[31:8]);
        e_ack = 1'b0; e_err = 1'b0; e_data = '0;
        if (in_win && rd && wr) begin
            e_err = 1'b1;
        end else if (in_win && rd) begin
            e_ack = 1'b1;
            if (w <= 8) e_data = rom_word(w);
            else if (w == 9) e_data = {30'h0, m_boot, m_lock};
            else if (w == 10) begin
`ifdef CELLRV32_SYSINFO_UPTIME_EN
                v = up_at(c);
                e_data = v[31:0];
                m_shadow = v[63:32];
`endif
            end else if (w == 11) begin
`ifdef CELLRV32_SYSINFO_UPTIME_EN
                e_data = m_shadow;
`endif
            end else if (w >= 16 && w < 16 + NSCR) e_data = m_scr[w - 16];
            else begin e_ack = 1'b0; e_err = 1'b1; end
        end else if (in_win && wr) begin
            e_err = 1'b1;
            if (w == 9) begin
                e_err = 1'b0; e_ack = 1'b1;
                old_lock = m_lock;
                m_lock = m_lock | d[0];
                if (!old_lock) m_boot = d[1];
            end else if (w >= 16 && w < 16 + NSCR && !m_lock) begin
                e_err = 1'b0; e_ack = 1'b1;
                m_scr[w - 16] = d;
            end
`ifdef CELLRV32_SYSINFO_UPTIME_EN
            else if (w == 10 && !m_lock) begin
                e_err = 1'b0; e_ack = 1'b1;
                up_base_val = '0;
                up_base_cyc = c;
            end
`endif
        end
        rden = rd; wren = wr; addr = a; wdata = d;
        if (in_win && (rd || wr)) exp_q.push_back({e_ack, e_err, e_data, 32'(c)});
        @(negedge clk);
        rden = 1'b0; wren = 1'b0;
    endtask

    task automatic rd_w(input int w);
        issue(1'b1, 1'b0, BASE + 32'(w * 4), 32'h0);
    endtask

    task automatic wr_w(input int w, input logic [31:0] d);
        issue(1'b0, 1'b1, BASE + 32'(w * 4), d);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [65:0] e;
        while (exp_q.size() > 0 && int'(exp_q[0][31:0]) < cyc) begin
            e = exp_q.pop_front();
            n_checks++; n_fail++;
            $display("FAIL missed@cyc%0d: response never compared", int'(e[31:0]));
        end
        if (exp_q.size() > 0 && int'(exp_q[0][31:0]) == cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({ack, err, rdata} !== e[65:32]) begin
                n_fail++;
                $display("FAIL resp@cyc%0d: got ack=%b err=%b data=%h want ack=%b err=%b data=%h",
                         cyc, ack, err, rdata, e[65], e[64], e[63:32]);
            end
        end else begin
            n_checks++;
            if ({ack, err, rdata} !== 34'h0) begin
                n_fail++;
                $display("FAIL idle@cyc%0d: got ack=%b err=%b data=%h want all 0", cyc, ack, err, rdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    int wl[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 16, 17, 19, 40};

    initial begin
        int          r, w;
        logic [31:0] a, d;
        rst = 1'b1; rden = 1'b0; wren = 1'b0; addr = '0; wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_data", rdata, 32'h0);
        check("reset_ack", {31'h0, ack}, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        rst = 1'b0;
        model_reset();

        // Basic reads/writes and error cases
        rd_w(0);
        @(negedge clk);
        wr_w(16, 32'hDEADBEEF);
        rd_w(16);
        rd_w(8);
        rd_w(40);
        issue(1'b1, 1'b1, BASE + 32'd64, 32'h12345678);
        rd_w(16);
        wr_w(2, 32'hFFFFFFFF);
        wr_w(11, 32'h1);
        rd_w(3);

        // Randomized traffic, lock bit kept clear
        for (int n = 0; n < 200; n++) begin
            w = wl[$urandom_range(0, 15)];
            a = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) a = 32'h00001000 + 32'(w * 4);
            d = $urandom;
            if (w == 9) d[0] = 1'b0;
            r = $urandom_range(0, 9);
            if (r == 0) issue(1'b1, 1'b1, a, d);
            else if (r <= 4) issue(1'b0, 1'b1, a, d);
            else issue(1'b1, 1'b0, a, d);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

`ifdef CELLRV32_SYSINFO_UPTIME_EN
        // Counter just below a 2^32 boundary; HI must reflect the LO-read snapshot
        force dut.uptime_q = 64'h0000_0001_FFFF_FFFC;
        #1;
        release dut.uptime_q;
        up_base_val = 64'h0000_0001_FFFF_FFFC;
        up_base_cyc = cyc;
        rd_w(10);
        repeat (5) @(negedge clk);
        rd_w(11);
        rd_w(10);
        rd_w(11);
        // Clear, then LO read three cycles later
        wr_w(10, 32'hFFFFFFFF);
        repeat (3) @(negedge clk);
        rd_w(10);
`else
        rd_w(10);
        rd_w(11);
        wr_w(10, 32'h5);
`endif

        // Lock behaviour
        wr_w(16, 32'hDEADBEEF);
        wr_w(9, 32'h3);
        wr_w(16, 32'h1);
        rd_w(16);
        rd_w(9);
        wr_w(9, 32'h0);
        rd_w(9);
        wr_w(10, 32'h0);

        // Reset in the cycle after a read request
        rden = 1'b1; addr = BASE + 32'd64;
        @(posedge clk);
        #1;
        rden = 1'b0;
        check("pre_reset_ack", {31'h0, ack}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_data", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        rd_w(16);
        rd_w(9);
        rd_w(11);
        rd_w(10);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
